mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/core_pkg.sv | 18 +
 rtl/arb_pick.sv | 49 ++++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and default widths for the memory arbiter slice.
package core_pkg;

   localparam int unsigned ADDR_W_DEF = 10;
   localparam int unsigned DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_e;

endpackage

// File: rtl/arb_pick.sv
// Winner select between fetch and data requesters.
// Optional macro RR_ARB_EN: ties alternate against the previous winner;
// without it, data always wins a tie and no last-winner state exists.
module arb_pick
   import core_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   i_if_req,
   input  logic   i_d_req,
   input  logic   i_pick_en,   // arbiter is in IDLE and will take the winner
   output logic   o_any,
   output owner_e o_winner
);

   assign o_any = i_if_req | i_d_req;

`ifdef RR_ARB_EN
   owner_e r_last;

   // Remember who won the last granted transaction; resets to fetch so data wins first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last <= OWN_IF;
      end else if (i_pick_en && o_any) begin
         r_last <= o_winner;
      end
   end

   // Single requester wins outright; a tie goes to whoever did not win last time.
   always_comb begin
      o_winner = OWN_D;
      if (i_if_req && !i_d_req) begin
         o_winner = OWN_IF;
      end else if (i_if_req && i_d_req && (r_last == OWN_D)) begin
         o_winner = OWN_IF;
      end
   end
`else
   logic w_unused;
   assign w_unused = clk ^ rst ^ i_pick_en;

   // Fixed priority: data first.
   always_comb begin
      o_winner = i_d_req ? OWN_D : OWN_IF;
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter in front of a single-port memory.
// One transaction at a time: IDLE -> ISSUE (mem_req until mem_ack) -> DONE -> IDLE.
// Optional macro RR_ARB_EN selects round-robin tie breaking in arb_pick.
module mem_arbiter
   import core_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   state_e            r_state;
   state_e            w_state_nxt;
   owner_e            r_owner;
   owner_e            w_winner;
   logic              w_any;
   logic              w_pick;
   logic              w_issue;
   logic              w_ack;
   logic [ADDR_W-1:0] r_addr;
   logic              r_we;
   logic [DATA_W-1:0] r_wdata;
   logic              r_if_gnt;
   logic              r_d_gnt;
   logic              r_if_rvalid;
   logic              r_d_rvalid;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_d_rdata;
   logic              r_busy;

   // Requests are only looked at in IDLE; in ISSUE/DONE they are ignored.
   assign w_pick  = (r_state == IDLE);
   assign w_issue = (r_state == ISSUE);
   // mem_ack only counts while a request is outstanding.
   assign w_ack   = w_issue & mem_ack;

   arb_pick u_arb_pick (
      .clk       (clk),
      .rst       (rst),
      .i_if_req  (if_req),
      .i_d_req   (d_req),
      .i_pick_en (w_pick),
      .o_any     (w_any),
      .o_winner  (w_winner)
   );

   // Next-state decode for the transaction FSM.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_any) w_state_nxt = ISSUE;
         ISSUE:   if (mem_ack) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State, busy, one-cycle grant and completion pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_busy      <= 1'b0;
         r_if_gnt    <= 1'b0;
         r_d_gnt     <= 1'b0;
         r_if_rvalid <= 1'b0;
         r_d_rvalid  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_busy      <= (w_state_nxt != IDLE);
         r_if_gnt    <= w_pick & w_any & (w_winner == OWN_IF);
         r_d_gnt     <= w_pick & w_any & (w_winner == OWN_D);
         r_if_rvalid <= w_ack & (r_owner == OWN_IF);
         r_d_rvalid  <= w_ack & (r_owner == OWN_D);
      end
   end

   // Latch the winner's request so the memory side sees it stable through ISSUE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_wdata <= '0;
         r_owner <= OWN_IF;
      end else if (w_pick && w_any) begin
         r_owner <= w_winner;
         if (w_winner == OWN_D) begin
            r_addr  <= d_addr;
            r_we    <= d_we;
            r_wdata <= d_wdata;
         end else begin
            r_addr  <= if_addr;
            r_we    <= 1'b0;
            r_wdata <= '0;
         end
      end
   end

   // Capture read data into the owning port's register; held until that port completes again.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_if_rdata <= '0;
         r_d_rdata  <= '0;
      end else if (w_ack) begin
         if (r_owner == OWN_IF) begin
            r_if_rdata <= mem_rdata;
         end else begin
            r_d_rdata <= mem_rdata;
         end
      end
   end

   assign mem_req   = w_issue;
   assign mem_we    = w_issue & r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign if_gnt    = r_if_gnt;
   assign d_gnt     = r_d_gnt;
   assign if_rvalid = r_if_rvalid;
   assign d_rvalid  = r_d_rvalid;
   assign if_rdata  = r_if_rdata;
   assign d_rdata   = r_d_rdata;
   assign busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (default and RR_ARB_EN builds).
module tb_mem_arbiter;

   localparam int unsigned AW = 10;
   localparam int unsigned DW = 32;

   logic          clk;
   logic          rst;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_rvalid;
   logic [DW-1:0] if_rdata;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_gnt;
   logic          d_rvalid;
   logic [DW-1:0] d_rdata;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;
   logic          busy;

   int n_checks;
   int n_errors;

   mem_arbiter #(
      .ADDR_W (AW),
      .DATA_W (DW)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one cycle and land 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int   f_left;
      int   d_left;
      int   n;
      logic win_d;
      logic exp_d;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] tag_data;

      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b1;
      if_req    = 1'b0;
      if_addr   = '0;
      d_req     = 1'b0;
      d_we      = 1'b0;
      d_addr    = '0;
      d_wdata   = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;

      // ---- reset state
      tick();
      tick();
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_busy", busy, 0);
      check("rst_gnts", {if_gnt, d_gnt}, 0);
      check("rst_rvalids", {if_rvalid, d_rvalid}, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_rdata", {if_rdata, d_rdata}, 0);
      rst = 1'b0;
      tick();

      // ---- single fetch, minimum latency
      if_req  = 1'b1;
      if_addr = 10'd5;
      check("f1_c0_gnt", if_gnt, 0);
      tick();
      check("f1_c1_if_gnt", if_gnt, 1);
      check("f1_c1_d_gnt", d_gnt, 0);
      check("f1_c1_mem_req", mem_req, 1);
      check("f1_c1_mem_we", mem_we, 0);
      check("f1_c1_mem_addr", mem_addr, 5);
      check("f1_c1_busy", busy, 1);
      if_req    = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEADBEEF;
      tick();
      mem_ack   = 1'b0;
      check("f1_c2_if_rvalid", if_rvalid, 1);
      check("f1_c2_d_rvalid", d_rvalid, 0);
      check("f1_c2_if_rdata", if_rdata, 32'hDEADBEEF);
      check("f1_c2_mem_req", mem_req, 0);
      check("f1_c2_if_gnt", if_gnt, 0);
      tick();
      check("f1_c3_if_rvalid", if_rvalid, 0);
      check("f1_c3_busy", busy, 0);
      check("f1_c3_rdata_hold", if_rdata, 32'hDEADBEEF);

      // ---- store with ack delayed 3 cycles
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 10'd28;
      d_wdata = 32'h1234;
      mem_rdata = '0;
      tick();
      check("st_d_gnt", d_gnt, 1);
      d_req = 1'b0;
      d_we  = 1'b0;
      for (int c = 0; c < 4; c++) begin
         check("st_mem_req", mem_req, 1);
         check("st_mem_we", mem_we, 1);
         check("st_mem_addr", mem_addr, 28);
         check("st_mem_wdata", mem_wdata, 32'h1234);
         check("st_rvalids_low", {if_rvalid, d_rvalid}, 0);
         if (c > 0) check("st_gnt_once", d_gnt, 0);
         if (c == 3) mem_ack = 1'b1;
         tick();
      end
      mem_ack = 1'b0;
      check("st_d_rvalid", d_rvalid, 1);
      check("st_if_rvalid", if_rvalid, 0);
      check("st_mem_req_drop", mem_req, 0);
      check("st_if_rdata_kept", if_rdata, 32'hDEADBEEF);
      tick();
      check("st_d_rvalid_pulse", d_rvalid, 0);
      check("st_idle", busy, 0);

      // ---- ties: both sides hold 4 accesses, renewing req right after each grant
      f_left  = 4;
      d_left  = 4;
      if_req  = 1'b1;
      if_addr = 10'd100;
      d_req   = 1'b1;
      d_we    = 1'b0;
      d_addr  = 10'd200;
      for (int g = 0; g < 8; g++) begin
         n = 0;
         do begin
            tick();
            n++;
         end while (!(if_gnt || d_gnt) && n < 10);
         if (!(if_gnt || d_gnt)) begin
            check("tie_gnt_timeout", 0, 1);
            break;
         end
`ifdef RR_ARB_EN
         exp_d = (g % 2 == 0);
`else
         exp_d = (g < 4);
`endif
         win_d = d_gnt;
         check("tie_order", win_d, exp_d);
         check("tie_one_gnt", if_gnt & d_gnt, 0);
         if (win_d) begin
            exp_addr = 10'(200 + 4 - d_left);
            d_left--;
            d_addr = 10'(200 + 4 - d_left);
            if (d_left == 0) d_req = 1'b0;
         end else begin
            exp_addr = 10'(100 + 4 - f_left);
            f_left--;
            if_addr = 10'(100 + 4 - f_left);
            if (f_left == 0) if_req = 1'b0;
         end
         check("tie_mem_addr", mem_addr, exp_addr);
         check("tie_mem_we", mem_we, 0);
         tag_data  = {8'hA0, 7'd0, win_d, 6'd0, exp_addr};
         mem_ack   = 1'b1;
         mem_rdata = tag_data;
         tick();
         mem_ack = 1'b0;
         check("tie_rvalid", {if_rvalid, d_rvalid}, win_d ? 2'b01 : 2'b10);
         check("tie_rdata", win_d ? d_rdata : if_rdata, tag_data);
      end
      if_req = 1'b0;
      d_req  = 1'b0;
      tick();
      tick();
      check("tie_end_idle", busy, 0);

      // ---- reset at the second ISSUE cycle with mem_ack high
      if_req  = 1'b1;
      if_addr = 10'd7;
      tick();
      check("rr_gnt", if_gnt, 1);
      if_req = 1'b0;
      tick();
      check("rr_still_issue", mem_req, 1);
      mem_ack   = 1'b1;
      mem_rdata = 32'h5555AAAA;
      #2;
      rst = 1'b1;
      #1;
      check("rr_mem_req_now", mem_req, 0);
      check("rr_busy_now", busy, 0);
      check("rr_mem_addr_now", mem_addr, 0);
      @(posedge clk);
      #1;
      check("rr_no_rvalid_in_rst", {if_rvalid, d_rvalid}, 0);
      mem_ack = 1'b0;
      rst     = 1'b0;
      tick();
      check("rr_no_rvalid_after", {if_rvalid, d_rvalid}, 0);
      check("rr_idle", busy, 0);
      check("rr_mem_req", mem_req, 0);
      check("rr_if_rdata_cleared", if_rdata, 0);

      // ---- stray mem_ack in IDLE, then fetch of addr 3
      mem_ack   = 1'b1;
      mem_rdata = 32'hBAD0BAD0;
      tick();
      mem_ack = 1'b0;
      check("stray_busy", busy, 0);
      check("stray_rvalid", {if_rvalid, d_rvalid}, 0);
      check("stray_rdata", {if_rdata, d_rdata}, 0);
      if_req  = 1'b1;
      if_addr = 10'd3;
      tick();
      check("stray_f_gnt", if_gnt, 1);
      check("stray_f_addr", mem_addr, 3);
      if_req    = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 32'hCAFE0003;
      tick();
      mem_ack = 1'b0;
      check("stray_f_rvalid", if_rvalid, 1);
      check("stray_f_rdata", if_rdata, 32'hCAFE0003);
      tick();
      check("stray_f_done", {if_rvalid, busy}, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
